uart_core_param: RTL and testbench
==================================

Name: uart_core_param

Overview:
- Parametrised full-duplex UART engine; next generation of the fixed 8N1 transmitter/receiver pair in the UART top design.
- Configurable data width, parity, stop bits and baud divisor.
- Valid/ready handshakes replace level enables; parity, framing and overrun detection are added.
- Sits between the board pins (tx_out/rx_in) and user logic; status outputs can drive LEDs.

Parameters:
- CLKS_PER_BIT, 1085, clock cycles per bit (125 MHz / 115200 baud); legal range is 4 or more.
- DATA_BITS, 8, payload width; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- tx_data  input  DATA_BITS  byte to transmit.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  transmitter idle; accepts tx_data this cycle.
- tx_out  output  1  serial line out; idles high.
- rx_in  input  1  serial line in; asynchronous to clk.
- rx_data  output  DATA_BITS  received payload.
- rx_valid  output  1  rx_data and error flags are valid.
- rx_ready  input  1  consumer accepts rx_data.
- rx_parity_err  output  1  parity mismatch on the held frame.
- rx_frame_err  output  1  a stop bit was sampled low on the held frame.
- rx_overrun  output  1  at least one frame was overwritten before being read.
- tx_busy  output  1  transmitter not idle.
- rx_busy  output  1  receiver not idle.

Behaviour:
- Reset (rst low, asynchronous):
  - Both FSMs go to IDLE; bit counters clear.
  - tx_out=1, tx_ready=1 on release, tx_busy=0, rx_busy=0.
  - rx_valid=0, rx_data=0, all error flags 0.
  - The rx_in 2-flop synchroniser presets to 1.
  - Reset mid-frame aborts the frame immediately; no partial output is delivered.
- TX FSM (IDLE, START, DATA, PAR, STOP):
  - Accept occurs on tx_valid && tx_ready in IDLE; tx_data is latched.
  - tx_out drives start bit 0 from the next cycle.
  - Each bit is held exactly CLKS_PER_BIT cycles. Data goes out LSB first.
  - PAR state is skipped when PARITY=0. Parity bit = XOR of data, inverted for odd.
  - STOP holds 1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE.
  - tx_ready is high only in IDLE. Back-to-back frames have a minimum 1-cycle idle gap.
  - tx_busy = !tx_ready.
- RX FSM (IDLE, START, DATA, PAR, STOP):
  - All sampling uses the synchronised rx_in; a falling edge in IDLE enters START.
  - START samples at CLKS_PER_BIT/2 (integer floor). If high, it is a false start: return to IDLE with no output.
  - Later bits are sampled every CLKS_PER_BIT cycles at bit centres, LSB first.
  - PAR compares the sampled parity bit against computed parity.
  - STOP samples each stop bit centre; any low sample sets the frame error.
  - After the centre sample of the final stop bit:
    - rx_data and the error flags load, and rx_valid rises on the next cycle.
    - The FSM returns to IDLE in the same cycle, so a following start bit is caught.
  - Frames with errors are still delivered, with their flags set.
  - rx_valid and the flags hold until rx_valid && rx_ready, then clear on the next cycle.
  - Overrun: a frame completes while rx_valid=1 and no handshake occurs in that cycle.
    - New data and flags overwrite the held ones; rx_overrun sets.
    - rx_overrun clears on the next handshake.
  - If a handshake and a completion coincide, the new frame loads, rx_valid stays 1, and there is no overrun.
  - rx_busy = FSM not in IDLE.
- Latencies:
  - tx_out falls 1 cycle after accept.
  - rx_valid rises 1 cycle after the final stop-bit sample, plus the 2-cycle synchroniser delay relative to the pin.

Optional Feature:
- UART_LOOPBACK_EN defined: the receiver input is internally muxed to the transmitter output (pre-pin), and rx_in is ignored; tx_out still drives the pin.
- Undefined: rx_in feeds the synchroniser directly; no mux is present.

Decomposition:
- Package uart_pkg:
  - Parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN.
  - Shared FSM state encoding (IDLE, START, DATA, PAR, STOP).
  - Function for parity computation.
- One sub-module: uart_bit_timer.
  - Counts to CLKS_PER_BIT (or half for start detection) and issues a tick.
  - Instantiated once in the TX path and once in the RX path.

Test Plan:
- CLKS_PER_BIT=16, 8N1; send 0x05 with tx_valid pulse -> tx_out: 0, then bits 1,0,1,0,0,0,0,0, then 1, each held 16 cycles; tx_ready low for 160 cycles.
- Loop tx_out to rx_in externally, PARITY=2, send 0xA3 -> rx_valid with rx_data=0xA3, rx_parity_err=0, rx_frame_err=0.
- Drive a frame with a corrupted parity bit, then a frame with stop=0 -> rx_parity_err=1, then rx_frame_err=1; data still delivered.
- Hold rx_ready=0 and receive 0x11 then 0x22 -> rx_data=0x22, rx_overrun=1; a handshake clears both.
- 5-cycle low glitch on rx_in (CLKS_PER_BIT=16) -> no rx_valid, FSM back in IDLE; assert rst mid-TX frame -> tx_out=1 immediately, tx_ready=1 after release.
- Define UART_LOOPBACK_EN with rx_in tied 0 -> send 0x5A; rx_data=0x5A with no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core:
// parity mode codes, common FSM state encoding and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  // Payload is zero-extended to 8 bits by the caller; extra zeros do not change the XOR.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// User-side handshake and status bundle of uart_core_param.
// master = user logic, slave = the UART core.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_busy;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;
  logic                 rx_busy;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_busy, rx_data, rx_valid,
           rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_busy, rx_data, rx_valid,
           rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: ticks once every CLKS_PER_BIT enabled cycles.
// restart loads a full period, or half a period when half=1 (start-bit centring).
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= FULL_LOAD;
    end else if (restart) begin
      count <= half ? HALF_LOAD : FULL_LOAD;
    end else if (en) begin
      count <= (count == '0) ? FULL_LOAD : count - 1'b1;
    end
  end
endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART engine with valid/ready handshakes and error flags.
// Define UART_LOOPBACK_EN to feed the receiver from the transmitter output instead of rx_in.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_core_param_if.slave  bus,
  output logic              tx_out,
  input  logic              rx_in
);

  // ---------------- transmitter ----------------
  uart_state_e          tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic [3:0]           tx_cnt;
  logic                 tx_par;
  logic                 tx_out_q;
  logic                 tx_ready_q;
  logic                 tx_tick;
  logic                 tx_accept;

  assign tx_accept   = bus.tx_valid && tx_ready_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_busy  = !tx_ready_q;
  assign tx_out       = tx_out_q;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (tx_accept),
    .half    (1'b0),
    .en      (tx_state != ST_IDLE),
    .tick    (tx_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= ST_IDLE;
      tx_shift   <= '0;
      tx_cnt     <= '0;
      tx_par     <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      case (tx_state)
        ST_IDLE: if (tx_accept) begin
          tx_shift   <= bus.tx_data;
          tx_par     <= calc_parity(8'(bus.tx_data), PARITY);
          tx_out_q   <= 1'b0;
          tx_ready_q <= 1'b0;
          tx_state   <= ST_START;
        end
        ST_START: if (tx_tick) begin
          tx_out_q <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_cnt   <= '0;
          tx_state <= ST_DATA;
        end
        ST_DATA: if (tx_tick) begin
          if (tx_cnt == 4'(DATA_BITS - 1)) begin
            tx_cnt <= '0;
            if (PARITY != PAR_NONE) begin
              tx_out_q <= tx_par;
              tx_state <= ST_PAR;
            end else begin
              tx_out_q <= 1'b1;
              tx_state <= ST_STOP;
            end
          end else begin
            tx_out_q <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_cnt   <= tx_cnt + 1'b1;
          end
        end
        ST_PAR: if (tx_tick) begin
          tx_out_q <= 1'b1;
          tx_state <= ST_STOP;
        end
        ST_STOP: if (tx_tick) begin
          if (tx_cnt == 4'(STOP_BITS - 1)) begin
            tx_cnt     <= '0;
            tx_ready_q <= 1'b1;
            tx_state   <= ST_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_line;
`ifdef UART_LOOPBACK_EN
  logic unused_rx_in;
  assign unused_rx_in = rx_in;
  assign rx_line      = tx_out_q;
`else
  assign rx_line = rx_in;
`endif

  logic [1:0] rx_sync;
  logic       rx_prev;
  logic       rx_s;
  logic       rx_fall;

  assign rx_s    = rx_sync[1];
  assign rx_fall = rx_prev && !rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rx_line};
      rx_prev <= rx_sync[1];
    end
  end

  uart_state_e          rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic [3:0]           rx_cnt;
  logic                 par_err;
  logic                 stop_err;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_perr_q;
  logic                 rx_ferr_q;
  logic                 rx_ovr_q;
  logic                 rx_tick;
  logic                 rx_hs;

  assign rx_hs             = rx_valid_q && bus.rx_ready;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;
  assign bus.rx_busy       = (rx_state != ST_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk     (clk),
    .rst     (rst),
    .restart ((rx_state == ST_IDLE) && rx_fall),
    .half    (1'b1),
    .en      (rx_state != ST_IDLE),
    .tick    (rx_tick)
  );

  // Handshake clears come first so a coinciding frame completion overrides them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= ST_IDLE;
      rx_shift   <= '0;
      rx_cnt     <= '0;
      par_err    <= 1'b0;
      stop_err   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      if (rx_hs) begin
        rx_valid_q <= 1'b0;
        rx_perr_q  <= 1'b0;
        rx_ferr_q  <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
      case (rx_state)
        ST_IDLE: if (rx_fall) begin
          rx_cnt   <= '0;
          par_err  <= 1'b0;
          stop_err <= 1'b0;
          rx_state <= ST_START;
        end
        ST_START: if (rx_tick) begin
          rx_state <= rx_s ? ST_IDLE : ST_DATA;
        end
        ST_DATA: if (rx_tick) begin
          rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_cnt == 4'(DATA_BITS - 1)) begin
            rx_cnt   <= '0;
            rx_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_PAR: if (rx_tick) begin
          par_err  <= (rx_s != calc_parity(8'(rx_shift), PARITY));
          rx_state <= ST_STOP;
        end
        ST_STOP: if (rx_tick) begin
          if (rx_cnt == 4'(STOP_BITS - 1)) begin
            rx_data_q  <= rx_shift;
            rx_perr_q  <= par_err;
            rx_ferr_q  <= stop_err || !rx_s;
            rx_valid_q <= 1'b1;
            if (rx_valid_q && !bus.rx_ready) rx_ovr_q <= 1'b1;
            rx_cnt   <= '0;
            rx_state <= ST_IDLE;
          end else begin
            stop_err <= stop_err || !rx_s;
            rx_cnt   <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed scoreboard bench for uart_core_param: an 8N1 instance for TX waveform/reset
// checks and an 8E2 instance for receive, error, overrun and loopback checks.
`timescale 1ns/1ps
module tb_uart_core_param;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_core_param_if #(.DATA_BITS(8)) bus_a ();
  uart_core_param_if #(.DATA_BITS(8)) bus_b ();

  logic tx_a, tx_b, rx_a_pin, rx_b_pin;
  logic drv_b  = 1'b1;
  logic loop_b = 1'b0;

  assign rx_a_pin = 1'b1;
  assign rx_b_pin = loop_b ? tx_b : drv_b;

  uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .tx_out(tx_a), .rx_in(rx_a_pin));

  uart_core_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .tx_out(tx_b), .rx_in(rx_b_pin));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rx_exp_t;

  rx_exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Even parity, two stop bits; bad_stop pulls only the first stop bit low.
  task automatic drive_frame_b(input logic [7:0] d, input logic bad_par, input logic bad_stop);
    drv_b = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      drv_b = d[i];
      cyc(CPB);
    end
    drv_b = (^d) ^ bad_par;
    cyc(CPB);
    drv_b = !bad_stop;
    cyc(CPB);
    drv_b = 1'b1;
    cyc(CPB);
  endtask

  task automatic send_tx_b(input logic [7:0] d);
    check("b_tx_ready_pre", 32'(bus_b.tx_ready), 32'd1);
    bus_b.tx_data  = d;
    bus_b.tx_valid = 1'b1;
    cyc(1);
    bus_b.tx_valid = 1'b0;
  endtask

  task automatic wait_rx_b(input int budget);
    rx_exp_t e;
    logic    got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (bus_b.rx_valid === 1'b1) got = 1'b1;
      else cyc(1);
    end
    check("rx_arrive", 32'(got), 32'd1);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    if (got) begin
      check("rx_data", 32'(bus_b.rx_data), 32'(e.data));
      check("rx_parity_err", 32'(bus_b.rx_parity_err), 32'(e.perr));
      check("rx_frame_err", 32'(bus_b.rx_frame_err), 32'(e.ferr));
      check("rx_overrun", 32'(bus_b.rx_overrun), 32'(e.ovr));
      bus_b.rx_ready = 1'b1;
      cyc(1);
      bus_b.rx_ready = 1'b0;
      check("rx_valid_clr", 32'(bus_b.rx_valid), 32'd0);
      check("rx_flags_clr", 32'({bus_b.rx_parity_err, bus_b.rx_frame_err, bus_b.rx_overrun}), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] fr_a;
    bus_a.tx_data = '0; bus_a.tx_valid = 1'b0; bus_a.rx_ready = 1'b0;
    bus_b.tx_data = '0; bus_b.tx_valid = 1'b0; bus_b.rx_ready = 1'b0;
    rst = 1'b0;
    cyc(3);
    check("rst_tx_out", 32'({tx_a, tx_b}), 32'h3);
    check("rst_tx_ready", 32'({bus_a.tx_ready, bus_b.tx_ready}), 32'h3);
    check("rst_busy", 32'({bus_a.tx_busy, bus_b.tx_busy, bus_b.rx_busy}), 32'h0);
    check("rst_rx_valid", 32'(bus_b.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus_b.rx_data), 32'd0);
    check("rst_flags", 32'({bus_b.rx_parity_err, bus_b.rx_frame_err, bus_b.rx_overrun}), 32'd0);
    rst = 1'b1;
    cyc(2);

    // 8N1 waveform of 0x05: start, LSB-first data, stop; 16 cycles per bit.
    fr_a = {1'b1, 8'h05, 1'b0};
    check("a_ready_pre", 32'(bus_a.tx_ready), 32'd1);
    bus_a.tx_data  = 8'h05;
    bus_a.tx_valid = 1'b1;
    cyc(1);
    bus_a.tx_valid = 1'b0;
    for (int k = 0; k < 10 * CPB; k++) begin
      check("a_tx_out", 32'(tx_a), 32'(fr_a[k / CPB]));
      check("a_tx_ready_low", 32'({bus_a.tx_ready, bus_a.tx_busy}), 32'h1);
      cyc(1);
    end
    check("a_tx_ready_end", 32'(bus_a.tx_ready), 32'd1);
    check("a_tx_idle", 32'({tx_a, bus_a.tx_busy}), 32'h2);
    cyc(4);

`ifdef UART_LOOPBACK_EN
    drv_b  = 1'b0;
    loop_b = 1'b0;
    cyc(4);
    sb.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_tx_b(8'h5A);
    wait_rx_b(400);
    cyc(20);
`else
    loop_b = 1'b1;
    sb.push_back('{data: 8'hA3, perr: 1'b0, ferr: 1'b0, ovr: 1'b0});
    send_tx_b(8'hA3);
    wait_rx_b(400);
    cyc(20);
    loop_b = 1'b0;
    cyc(4);

    sb.push_back('{data: 8'h3C, perr: 1'b1, ferr: 1'b0, ovr: 1'b0});
    drive_frame_b(8'h3C, 1'b1, 1'b0);
    wait_rx_b(100);
    cyc(4);

    sb.push_back('{data: 8'hC5, perr: 1'b0, ferr: 1'b1, ovr: 1'b0});
    drive_frame_b(8'hC5, 1'b0, 1'b1);
    wait_rx_b(100);
    cyc(4);

    drive_frame_b(8'h11, 1'b0, 1'b0);
    check("ovr_first_valid", 32'(bus_b.rx_valid), 32'd1);
    check("ovr_first_data", 32'(bus_b.rx_data), 32'h11);
    sb.push_back('{data: 8'h22, perr: 1'b0, ferr: 1'b0, ovr: 1'b1});
    drive_frame_b(8'h22, 1'b0, 1'b0);
    wait_rx_b(100);
    cyc(4);

    // 5-cycle low glitch is gone by the half-bit start sample.
    drv_b = 1'b0;
    cyc(5);
    drv_b = 1'b1;
    check("glitch_busy", 32'(bus_b.rx_busy), 32'd1);
    cyc(20);
    check("glitch_idle", 32'(bus_b.rx_busy), 32'd0);
    check("glitch_no_valid", 32'(bus_b.rx_valid), 32'd0);
`endif

    // Reset in the middle of a TX frame.
    bus_a.tx_data  = 8'h00;
    bus_a.tx_valid = 1'b1;
    cyc(1);
    bus_a.tx_valid = 1'b0;
    cyc(40);
    check("midrst_pre_low", 32'(tx_a), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_tx_out", 32'(tx_a), 32'd1);
    check("midrst_busy", 32'(bus_a.tx_busy), 32'd0);
    check("midrst_rx_valid", 32'(bus_b.rx_valid), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("midrst_ready", 32'(bus_a.tx_ready), 32'd1);
    check("midrst_idle_high", 32'(tx_a), 32'd1);
    cyc(3 * CPB);
    check("midrst_stays_idle", 32'({tx_a, bus_a.tx_busy}), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
